pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 8: number of cycles pll_reset is held high after power-up or retry, range 1..65535.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 50000: maximum number of cycles to wait for lock per attempt, range 1..65535.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive synchronized-lock-high cycles required before ready, range 1..65535.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: number of timeout retries before fault, range 0..15.
REQ-005 SHALL have port clk, input, 1: sole clock (PLL reference clock domain).
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: request that the PLL run.
REQ-008 SHALL have port pll_lock, input, 1: asynchronous PLL lock indication.
REQ-009 SHALL have port pll_pwd, output, 1: PLL power-down control.
REQ-010 SHALL have port pll_reset, output, 1: PLL reset control.
REQ-011 SHALL have port ready, output, 1: PLL outputs are stable and downstream reset may be released.
REQ-012 SHALL have port fault, output, 1: lock retries are exhausted.
REQ-013 SHALL have port retry_count, output, 4: number of timeouts in the current enable session.

Function
REQ-014 SHALL pass pll_lock through a 2-flop synchronizer; all lock decisions use the synchronized lock_s.
REQ-015 SHALL implement the states IDLE, RST, WAIT_LOCK, STABLE, READY and FAULT, using one 16-bit timer.
REQ-016 SHALL drive the outputs per state, registered:
- IDLE: pwd=1, rst=1.
- RST: pwd=0, rst=1.
- WAIT_LOCK and STABLE: pwd=0, rst=0.
- READY: pwd=0, rst=0, ready=1.
- FAULT: pwd=1, rst=1, fault=1.
REQ-017 SHALL in IDLE move to RST when enable=1, clearing the timer and retry_count.
REQ-018 SHALL stay in RST for exactly RST_CYCLES cycles, then move to WAIT_LOCK with the timer cleared.
REQ-019 SHALL in WAIT_LOCK move to STABLE when lock_s=1; otherwise, when the timer reaches LOCK_TIMEOUT_CYCLES, move to RST with retry_count+1 if retry_count<MAX_RETRIES, or else to FAULT.
REQ-020 SHALL in STABLE move to READY after LOCK_STABLE_CYCLES consecutive lock_s=1 cycles; if lock_s=0, return to WAIT_LOCK with the timer cleared and retry_count unchanged.
REQ-021 SHALL in READY move to RST when lock_s=0 (lock loss), clearing retry_count.
REQ-022 SHALL hold FAULT until enable=0.
REQ-023 SHALL move to IDLE on the next edge from any state when enable=0; this takes priority over all other transitions.
REQ-024 SHALL, when enable=0 and lock_s events occur in the same cycle, give enable priority; when timeout and lock_s=1 occur in the same cycle, give lock priority (go to STABLE).
REQ-025 SHALL, with pll_lock held high, assert ready exactly LOCK_STABLE_CYCLES+3 edges after the first edge sampling pll_lock=1 in WAIT_LOCK.
REQ-026 SHALL saturate the timer, never wrapping.

Reset
REQ-027 SHALL on reset=1 set the state to IDLE, pll_pwd=1, pll_reset=1, ready=0, fault=0, retry_count=0, timer=0, and the synchronizer flops to 0.
REQ-028 SHALL, if reset asserts mid-sequence including READY, drop ready on the next edge and restart from IDLE.

Configuration
REQ-029 SHALL, with PLL_SEQ_LOSS_COUNTER_EN defined, add output loss_count (8 bits): incremented on each READY->RST lock loss, saturating at 255, cleared by reset only (not by enable).
REQ-030 SHALL, without PLL_SEQ_LOSS_COUNTER_EN, omit the loss_count port and its logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover nominal bring-up: RST_CYCLES=4, LOCK_STABLE_CYCLES=16; enable=1, pll_lock high 10 cycles after pll_reset falls -> pll_reset high exactly 4 cycles, ready rises 19 edges after lock is sampled.
REQ-032 SHALL cover timeout retry: LOCK_TIMEOUT_CYCLES=100, MAX_RETRIES=2, pll_lock tied 0 -> 3 RST pulses, retry_count 0->1->2, fault=1 with pll_pwd=1 after the 3rd timeout.
REQ-033 SHALL cover lock glitch in STABLE: pll_lock drops 1 cycle at stable count 10 -> no ready at the nominal time; ready rises 16+3 edges after lock returns; retry_count unchanged.
REQ-034 SHALL cover lock loss in READY: pll_lock falls -> ready=0 within 3 edges, pll_reset pulse of RST_CYCLES, re-lock -> ready again; loss_count=1 when the macro is defined.
REQ-035 SHALL cover enable drop: enable=0 while in FAULT, and separately mid-WAIT_LOCK -> IDLE next edge, fault=0, pll_pwd=1; re-enable restarts with retry_count=0.
REQ-036 SHALL cover synchronous reset in READY: reset pulsed 1 cycle -> all outputs at reset values on the next edge; no reaction to an unclocked reset pulse between edges.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / lock sequencer: reset pulse, lock wait with retry, stability qualification.
// Optional lock-loss counter output when PLL_SEQ_LOSS_COUNTER_EN is defined.
module pll_lock_sequencer #(
   parameter int RST_CYCLES          = 8,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       pll_lock,
   output logic       pll_pwd,
   output logic       pll_reset,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_count
`ifdef PLL_SEQ_LOSS_COUNTER_EN
   ,
   output logic [7:0] loss_count
`endif
);

   localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [15:0] STB_CNT  = 16'(LOCK_STABLE_CYCLES);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      IDLE, RST, WAIT_LOCK, STABLE, READY, FAULT
   } state_t;

   state_t      state;
   logic [15:0] timer;
   logic        lock_meta;
   logic        lock_s;
   logic [15:0] timer_inc;

   assign timer_inc = (timer == 16'hFFFF) ? timer : timer + 16'd1;

   // Outputs are written together with the state they belong to, so they
   // change on the same edge as the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         lock_meta   <= 1'b0;
         lock_s      <= 1'b0;
         pll_pwd     <= 1'b1;
         pll_reset   <= 1'b1;
         ready       <= 1'b0;
         fault       <= 1'b0;
         retry_count <= '0;
`ifdef PLL_SEQ_LOSS_COUNTER_EN
         loss_count  <= '0;
`endif
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;
         if (!enable) begin
            state     <= IDLE;
            pll_pwd   <= 1'b1;
            pll_reset <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state       <= RST;
                  timer       <= '0;
                  retry_count <= '0;
                  pll_pwd     <= 1'b0;
                  pll_reset   <= 1'b1;
               end
               RST: begin
                  if (timer == RST_LAST) begin
                     state     <= WAIT_LOCK;
                     timer     <= '0;
                     pll_reset <= 1'b0;
                  end else begin
                     timer <= timer_inc;
                  end
               end
               WAIT_LOCK: begin
                  // Lock wins over a coincident timeout.
                  if (lock_s) begin
                     state <= STABLE;
                     timer <= '0;
                  end else if (timer == TO_LAST) begin
                     if (retry_count < RETRY_MAX) begin
                        state       <= RST;
                        timer       <= '0;
                        retry_count <= retry_count + 4'd1;
                        pll_reset   <= 1'b1;
                     end else begin
                        state     <= FAULT;
                        pll_pwd   <= 1'b1;
                        pll_reset <= 1'b1;
                        fault     <= 1'b1;
                     end
                  end else begin
                     timer <= timer_inc;
                  end
               end
               STABLE: begin
                  if (!lock_s) begin
                     state <= WAIT_LOCK;
                     timer <= '0;
                  end else if (timer == STB_CNT) begin
                     state <= READY;
                     ready <= 1'b1;
                  end else begin
                     timer <= timer_inc;
                  end
               end
               READY: begin
                  if (!lock_s) begin
                     state       <= RST;
                     timer       <= '0;
                     retry_count <= '0;
                     ready       <= 1'b0;
                     pll_reset   <= 1'b1;
`ifdef PLL_SEQ_LOSS_COUNTER_EN
                     if (loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
`endif
                  end
               end
               FAULT: begin
                  state <= FAULT;
               end
               default: begin
                  state     <= IDLE;
                  pll_pwd   <= 1'b1;
                  pll_reset <= 1'b1;
                  ready     <= 1'b0;
                  fault     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock/enable traffic
// against a deadline-based reference model.
module tb_pll_lock_sequencer;

   localparam int RC  = 4;
   localparam int LTC = 100;
   localparam int LSC = 16;
   localparam int MR  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       pll_lock = 1'b0;
   logic       pll_pwd, pll_reset, ready, fault;
   logic [3:0] retry_count;
`ifdef PLL_SEQ_LOSS_COUNTER_EN
   logic [7:0] loss_count;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pll_lock_sequencer #(
      .RST_CYCLES(RC), .LOCK_TIMEOUT_CYCLES(LTC),
      .LOCK_STABLE_CYCLES(LSC), .MAX_RETRIES(MR)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .pll_lock(pll_lock),
      .pll_pwd(pll_pwd), .pll_reset(pll_reset), .ready(ready), .fault(fault),
      .retry_count(retry_count)
`ifdef PLL_SEQ_LOSS_COUNTER_EN
      , .loss_count(loss_count)
`endif
   );

   // Reference model: phases with absolute-cycle deadlines.
   localparam int P_OFF = 0, P_RST = 1, P_WAIT = 2, P_STAB = 3, P_RDY = 4, P_FLT = 5;
   int ph = P_OFF;
   int cyc = 0;
   int rst_until, wait_until, ready_at;
   int retries = 0;
   int losses = 0;
   bit s1 = 0, s2 = 0, mvalid = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit en, input bit lk);
      bit ls;
      ls = s2;
      cyc++;
      if (r) begin
         ph = P_OFF; retries = 0; losses = 0; s1 = 0; s2 = 0; mvalid = 1;
      end else begin
         s2 = s1;
         s1 = lk;
         if (!en) ph = P_OFF;
         else begin
            case (ph)
               P_OFF: begin ph = P_RST; rst_until = cyc + RC; retries = 0; end
               P_RST: if (cyc == rst_until) begin ph = P_WAIT; wait_until = cyc + LTC; end
               P_WAIT: begin
                  // lock sample +2 edges reaches here; ready is due LSC+3 after the sample
                  if (ls) begin ph = P_STAB; ready_at = cyc + LSC + 1; end
                  else if (cyc == wait_until) begin
                     if (retries < MR) begin retries++; ph = P_RST; rst_until = cyc + RC; end
                     else ph = P_FLT;
                  end
               end
               P_STAB: begin
                  if (!ls) begin ph = P_WAIT; wait_until = cyc + LTC; end
                  else if (cyc == ready_at) ph = P_RDY;
               end
               P_RDY: if (!ls) begin
                  ph = P_RST; rst_until = cyc + RC; retries = 0;
                  if (losses < 255) losses++;
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic tick();
      bit r, e, l;
      bit ep, er;
      r = reset; e = enable; l = pll_lock;
      @(posedge clk);
      model_edge(r, e, l);
      #1;
      if (mvalid) begin
         ep = (ph == P_OFF) || (ph == P_FLT);
         er = (ph == P_OFF) || (ph == P_RST) || (ph == P_FLT);
         chk("m_pwd", 16'(pll_pwd), 16'(ep));
         chk("m_rst", 16'(pll_reset), 16'(er));
         chk("m_ready", 16'(ready), 16'(ph == P_RDY));
         chk("m_fault", 16'(fault), 16'(ph == P_FLT));
         chk("m_retry", 16'(retry_count), 16'(retries));
`ifdef PLL_SEQ_LOSS_COUNTER_EN
         chk("m_loss", 16'(loss_count), 16'(losses));
`endif
      end
   endtask

   task automatic wait_ready(input int start, input int bound, output int lat);
      lat = -1;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (ready === 1'b1) begin
            lat = cyc - start;
            break;
         end
      end
   endtask

   int n, cnt, lat, st, ret, pulses, run;
   bit prev, cur;

   initial begin
      // reset state
      reset = 1'b1; enable = 1'b0; pll_lock = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_pwd", 16'(pll_pwd), 16'd1);
      chk("rst_reset", 16'(pll_reset), 16'd1);
      chk("rst_ready", 16'(ready), 16'd0);
      chk("rst_fault", 16'(fault), 16'd0);
      chk("rst_retry", 16'(retry_count), 16'd0);

      // nominal bring-up
      enable = 1'b1;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (!pll_pwd && pll_reset) cnt++;
         if (!pll_pwd && !pll_reset) break;
      end
      chk("nom_rst_len", 16'(cnt), 16'(RC));
      repeat (9) tick();
      pll_lock = 1'b1;
      tick();
      st = cyc;
      wait_ready(st, 200, lat);
      chk("nom_latency", 16'(lat), 16'(LSC + 3));

      // lock loss in READY
      pll_lock = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick(); n++;
         if (!ready) break;
      end
      chk("loss_drop_le3", 16'(n <= 3 && ready == 1'b0), 16'd1);
      pll_lock = 1'b1;
      cnt = (!pll_pwd && pll_reset) ? 1 : 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (!pll_reset) break;
         if (!pll_pwd && pll_reset) cnt++;
      end
      chk("loss_rst_len", 16'(cnt), 16'(RC));
      wait_ready(cyc, 100, lat);
      chk("loss_relock", 16'(ready), 16'd1);
`ifdef PLL_SEQ_LOSS_COUNTER_EN
      chk("loss_count", 16'(loss_count), 16'd1);
`endif

      // reset pulse between edges is ignored; clocked reset clears everything
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      tick();
      chk("unclocked_rst", 16'(ready), 16'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("srst_ready", 16'(ready), 16'd0);
      chk("srst_pwd", 16'(pll_pwd), 16'd1);
      chk("srst_reset", 16'(pll_reset), 16'd1);
      chk("srst_fault", 16'(fault), 16'd0);
`ifdef PLL_SEQ_LOSS_COUNTER_EN
      chk("srst_loss", 16'(loss_count), 16'd0);
`endif

      // lock glitch at stable count 10
      for (int i = 0; i < 50 && ph != P_STAB; i++) tick();
      st = cyc;
      for (int i = 0; i < 20 && cyc < st + 10; i++) tick();
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      tick();
      ret = cyc;
      wait_ready(ret, 100, lat);
      chk("glitch_latency", 16'(lat), 16'(LSC + 3));
      chk("glitch_retry", 16'(retry_count), 16'd0);

      // timeout retries into FAULT
      pll_lock = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      pulses = 0;
      prev = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         cur = !pll_pwd && pll_reset;
         if (cur && !prev) begin
            chk($sformatf("to_retry_p%0d", pulses), 16'(retry_count), 16'(pulses));
            pulses++;
         end
         prev = cur;
         if (fault) break;
      end
      chk("to_pulses", 16'(pulses), 16'd3);
      chk("to_fault", 16'(fault), 16'd1);
      chk("to_pwd", 16'(pll_pwd), 16'd1);
      chk("to_retry", 16'(retry_count), 16'(MR));

      // enable drop in FAULT, re-enable
      enable = 1'b0;
      tick();
      chk("fdrop_fault", 16'(fault), 16'd0);
      chk("fdrop_pwd", 16'(pll_pwd), 16'd1);
      enable = 1'b1;
      tick();
      chk("fre_retry", 16'(retry_count), 16'd0);
      chk("fre_pwd", 16'(pll_pwd), 16'd0);

      // enable drop mid-WAIT_LOCK after one retry
      for (int i = 0; i < 300; i++) begin
         tick();
         if (retry_count == 4'd1 && !pll_pwd && !pll_reset) break;
      end
      chk("wdrop_retry1", 16'(retry_count), 16'd1);
      repeat (20) tick();
      enable = 1'b0;
      tick();
      chk("wdrop_pwd", 16'(pll_pwd), 16'd1);
      chk("wdrop_fault", 16'(fault), 16'd0);
      enable = 1'b1;
      tick();
      chk("wre_retry", 16'(retry_count), 16'd0);

      // random lock / enable / reset traffic
      run = 0;
      for (int i = 0; i < 3000; i++) begin
         if (run == 0) begin
            pll_lock = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 150);
         end
         run--;
         if ($urandom_range(0, 299) == 0) enable = ~enable;
         reset = ($urandom_range(0, 999) == 0);
         tick();
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
